sim_sample_uart_tx: RTL and testbench
=====================================

Name: sim_sample_uart_tx

Overview:
- Reader side of the circuit-simulator output interface.
- Watches the solver phase signal, captures each new fixed-point node-voltage sample (16-bit integer part plus 16-bit fraction part), and optionally decimates the samples.
- Buffers captured samples in a FIFO and streams them to the host PC as framed 8N1 UART bytes.
- Sits between the simulator core and the board's UART pin.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (minimum 2).
- FIFO_DEPTH, 16, sample-word FIFO depth; must be a power of 2, minimum 2.
- DECIM, 1, forward one of every DECIM samples (minimum 1).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; one clock, asynchronous, active-low.
- sample_i  input  1  solver phase toggle; its 1->0 transition marks a new valid voltage sample.
- v_int_i  input  16  voltage integer part (Q16.16 bits [47:32] of the solver state).
- v_frac_i  input  16  voltage fraction part (bits [31:16]).
- enable_i  input  1  capture enable.
- clr_ovf_i  input  1  clears sticky overflow.
- tx_o  output  1  UART serial out, idle high.
- busy_o  output  1  high while a frame is being shifted.
- overflow_o  output  1  sticky: a sample was dropped because the FIFO was full.
- fifo_level_o  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_ni=0):
  - Outputs: tx_o=1, busy_o=0, overflow_o=0, fifo_level_o=0.
  - FIFO emptied, decimation counter=0, FSM=IDLE, edge register=0.
  - Asserting reset mid-frame aborts the frame and tx_o goes high immediately; no partial frame resumes after release.
- Edge detect:
  - s_q is sample_i registered.
  - strobe = s_q & ~sample_i, evaluated at a clock edge.
  - v_int_i/v_frac_i are captured on that same edge and must be stable there.
- Decimation:
  - On each strobe with enable_i=1, dcnt counts 0..DECIM-1 and wraps.
  - A push is requested only when dcnt==0 before the increment.
  - With enable_i=0, strobes are ignored and dcnt holds.
- FIFO (32-bit words = {v_int, v_frac}):
  - The push writes on the strobe edge.
  - When full, a push without a simultaneous pop is dropped and overflow_o is set on that edge.
  - A push and pop on the same edge while full: both succeed, level unchanged.
  - overflow_o clears on an edge with clr_ovf_i=1 and no new drop; a drop on that same edge wins.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame format: 5 bytes in order: 0xA5, v_int[15:8], v_int[7:0], v_frac[15:8], v_frac[7:0].
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLK_DIV cycles.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop the word into the shadow register, byte index=0, go to START, busy_o=1.
  - Latency: a word pushed into an empty FIFO at edge k gives tx_o=0 from edge k+1.
  - START: tx_o=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: tx_o=byte[bit]; after CLK_DIV cycles, bit index increments; after bit 7, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles. Then, if byte index<4: index increments and go to START. Otherwise go to IDLE.
  - If the FIFO is non-empty when STOP ends on byte 4, IDLE pops on the next edge, giving exactly one idle-high cycle between frames. busy_o is 0 in that cycle.
- The shadow register isolates the frame in flight; pushes during a frame never alter it.
- enable_i=0 does not stop draining queued words or the current frame.
- All outputs are registered; tx_o is glitch-free.

Test Plan:
- CLK_DIV=4, DECIM=1, one falling sample_i with v_int=0x000A, v_frac=0x8000 -> tx_o bytes A5,00,0A,80,00. Each byte lasts 40 cycles; tx_o falls 1 cycle after the push; busy_o drops after 200 cycles.
- DECIM=3, six strobes with v_int=1..6 -> exactly two frames, carrying v_int=1 and v_int=4.
- FIFO_DEPTH=4, 8 back-to-back strobes during a frame -> the first word is popped at once and 4 more are queued (level 4). The remaining 3 are dropped and overflow_o=1. After the FIFO drains, clr_ovf_i gives overflow_o=0, and a drop coinciding with clr_ovf_i keeps overflow_o=1.
- Full FIFO with a push on the same edge as the IDLE pop -> level stays at FIFO_DEPTH and overflow_o stays 0.
- rst_ni pulsed low during the DATA bit of byte 2 -> tx_o=1 immediately and level=0. After release, tx_o stays high until a new strobe.
- enable_i=0 with 3 queued words and 5 strobes -> the 3 queued frames are sent, no new pushes occur, and dcnt is unchanged.

Source files
------------

// File: rtl/sim_sample_uart_tx_if.sv
// sim_sample_uart_tx_if
//   Groups the sample-capture bus and the UART/status outputs of
//   sim_sample_uart_tx. The simulator-side producer (or a bench) uses the
//   master modport; the UART reader itself uses the slave modport.
//   sample_i     : solver phase toggle, a 1->0 transition marks a new sample
//   v_int_i      : voltage integer part (Q16.16 bits [47:32])
//   v_frac_i     : voltage fraction part (bits [31:16])
//   enable_i     : capture enable
//   clr_ovf_i    : clears the sticky overflow flag
//   tx_o         : UART serial out, idle high
//   busy_o       : high while a frame is being shifted
//   overflow_o   : sticky sample-drop flag
//   fifo_level_o : current FIFO occupancy
interface sim_sample_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          sample_i;
    logic [15:0]                   v_int_i;
    logic [15:0]                   v_frac_i;
    logic                          enable_i;
    logic                          clr_ovf_i;
    logic                          tx_o;
    logic                          busy_o;
    logic                          overflow_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;

    modport master (
        output sample_i, v_int_i, v_frac_i, enable_i, clr_ovf_i,
        input  tx_o, busy_o, overflow_o, fifo_level_o
    );

    modport slave (
        input  sample_i, v_int_i, v_frac_i, enable_i, clr_ovf_i,
        output tx_o, busy_o, overflow_o, fifo_level_o
    );
endinterface

// File: rtl/sim_sample_uart_tx.sv
// sim_sample_uart_tx
//   Captures fixed-point node-voltage samples from the circuit simulator on
//   each falling edge of the solver phase signal, optionally keeps one of
//   every DECIM samples, queues them in a FIFO and streams each one to the
//   host as a 5-byte 8N1 UART frame: 0xA5, v_int[15:8], v_int[7:0],
//   v_frac[15:8], v_frac[7:0].
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : sample inputs and UART/status outputs (slave side)
module sim_sample_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int DECIM      = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    sim_sample_uart_tx_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hA5;
            3'd1:    b = w[31:24];
            3'd2:    b = w[23:16];
            3'd3:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // capture / FIFO state
    logic              s_q;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;

    // transmitter state
    state_t            state_q, state_d;
    logic [CW-1:0]     div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic strobe, capture, push_req, push_ok, pop, drop, empty, full, div_last;
    logic [7:0] cur_byte;

    // ---------------- capture, decimation, FIFO bookkeeping ----------------
    always_comb begin
        strobe   = s_q & ~bus.sample_i;
        capture  = strobe & bus.enable_i;
        push_req = capture & (dcnt_q == '0);
        empty    = (level_q == '0);
        full     = (level_q == LW'(FIFO_DEPTH));
        // the transmitter drains the FIFO only from IDLE
        pop      = (state_q == IDLE) & ~empty;
        // a pop on the same edge frees the slot, so a full FIFO still accepts
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;

        dcnt_d = dcnt_q;
        if (capture)
            dcnt_d = (dcnt_q == DW'(DECIM - 1)) ? '0 : dcnt_q + DW'(1);

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // a drop on the clearing edge keeps the flag set
        ovf_d = drop ? 1'b1 : (bus.clr_ovf_i ? 1'b0 : ovf_q);
    end

    // ---------------- transmit FSM ----------------
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        div_last = (div_q == CW'(CLK_DIV - 1));

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shadow_d = mem_q[rptr_q];
                    byte_d   = 3'd0;
                    div_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            DATA: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            STOP: begin
                if (div_last) begin
                    div_d = '0;
                    if (byte_q < 3'd4) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // tx/busy are registered from the next state so the pin changes
        // on the same edge as the state and never glitches
        cur_byte = frame_byte(shadow_d, byte_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FIFO storage needs no reset; only the pointers/level define content
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= {bus.v_int_i, bus.v_frac_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_q      <= 1'b0;
            dcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 3'd0;
            shadow_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            s_q      <= bus.sample_i;
            dcnt_q   <= dcnt_d;
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.tx_o         = tx_q;
    assign bus.busy_o       = busy_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.fifo_level_o = level_q;
endmodule

// File: tb/tb_sim_sample_uart_tx.sv
// Bench for sim_sample_uart_tx: two instances (DECIM=1 and DECIM=3, both
// CLK_DIV=4, FIFO_DEPTH=4) checked every cycle against a frame-level model,
// plus directed checks with hand-computed values.
module tb_sim_sample_uart_tx;
    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 50 * CD;
    localparam int TMAX  = 12000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sim_sample_uart_tx_if #(.FIFO_DEPTH(DEPTH)) b0 ();
    sim_sample_uart_tx_if #(.FIFO_DEPTH(DEPTH)) b1 ();

    sim_sample_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .DECIM(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b0));
    sim_sample_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .DECIM(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b1));

    // stimulus per instance
    logic        samp [2];
    logic [15:0] vint [2];
    logic [15:0] vfrac[2];
    logic        en   [2];
    logic        clr  [2];
    // observed outputs per instance
    logic        txw  [2];
    logic        busyw[2];
    logic        ovfw [2];
    logic [2:0]  lvlw [2];

    assign b0.sample_i = samp[0];  assign b1.sample_i = samp[1];
    assign b0.v_int_i  = vint[0];  assign b1.v_int_i  = vint[1];
    assign b0.v_frac_i = vfrac[0]; assign b1.v_frac_i = vfrac[1];
    assign b0.enable_i = en[0];    assign b1.enable_i = en[1];
    assign b0.clr_ovf_i = clr[0];  assign b1.clr_ovf_i = clr[1];
    assign txw[0] = b0.tx_o;         assign txw[1] = b1.tx_o;
    assign busyw[0] = b0.busy_o;     assign busyw[1] = b1.busy_o;
    assign ovfw[0] = b0.overflow_o;  assign ovfw[1] = b1.overflow_o;
    assign lvlw[0] = b0.fifo_level_o; assign lvlw[1] = b1.fifo_level_o;

    // ---------------- frame-level model ----------------
    // Queue of words, a sticky drop flag, and for the frame in flight only the
    // word and the number of bit-cycles left; tx is derived arithmetically.
    logic        mprev[2];
    int          mdcnt[2];
    logic [31:0] mq   [2][DEPTH];
    int          mh   [2];
    int          mc   [2];
    int          mrem [2];
    logic [31:0] mword[2];
    logic        movf [2];

    function automatic int dec_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] fbyte(input logic [31:0] w, input int by);
        case (by)
            0:       return 8'hA5;
            1:       return w[31:24];
            2:       return w[23:16];
            3:       return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic exp_tx(input int i);
        int pos, bt, n;
        logic [7:0] b;
        if (mrem[i] == 0) return 1'b1;
        pos = FLEN - mrem[i];
        bt  = pos / CD;
        n   = bt % 10;
        b   = fbyte(mword[i], bt / 10);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return b[n-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mprev[i] = 1'b0; mdcnt[i] = 0; mh[i] = 0; mc[i] = 0;
                mrem[i] = 0; mword[i] = '0; movf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic pop_m, push_m, drop_m, stb_m;
                pop_m = (mrem[i] == 0) && (mc[i] > 0);
                if (mrem[i] > 0) mrem[i] = mrem[i] - 1;
                stb_m = mprev[i] & ~samp[i];
                mprev[i] = samp[i];
                push_m = 1'b0;
                if (stb_m && en[i]) begin
                    push_m = (mdcnt[i] == 0);
                    mdcnt[i] = (mdcnt[i] + 1) % dec_of(i);
                end
                drop_m = push_m && (mc[i] == DEPTH) && !pop_m;
                if (pop_m) begin
                    mword[i] = mq[i][mh[i]];
                    mh[i] = (mh[i] + 1) % DEPTH;
                    mc[i] = mc[i] - 1;
                    mrem[i] = FLEN;
                end
                if (push_m && !drop_m) begin
                    mq[i][(mh[i] + mc[i]) % DEPTH] = {vint[i], vfrac[i]};
                    mc[i] = mc[i] + 1;
                end
                movf[i] = drop_m ? 1'b1 : (clr[i] ? 1'b0 : movf[i]);
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic trace[2][TMAX];
    logic [31:0] dw[8];
    int dbad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // advance one cycle; sample at the falling edge and compare against model
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cyc >= TMAX - FLEN - 2) begin
            $display("FAIL cycle_budget: got %0d want <%0d", cyc, TMAX - FLEN - 2);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
            $fatal(1, "cycle budget exhausted");
        end
        for (int i = 0; i < 2; i++) begin
            trace[i][cyc] = txw[i];
            if (rst_n) begin
                chk($sformatf("tx%0d", i),   32'(txw[i]),   32'(exp_tx(i)));
                chk($sformatf("busy%0d", i), 32'(busyw[i]), 32'(mrem[i] > 0));
                chk($sformatf("ovf%0d", i),  32'(ovfw[i]),  32'(movf[i]));
                chk($sformatf("lvl%0d", i),  32'(lvlw[i]),  32'(mc[i]));
            end
        end
    endtask

    task automatic strobe(input int i, input logic [15:0] vi, input logic [15:0] vf);
        samp[i] = 1'b1;
        tick();
        samp[i] = 1'b0; vint[i] = vi; vfrac[i] = vf;
        tick();
    endtask

    task automatic wait_drain(input int i, input string nm);
        int w;
        w = 0;
        while (!(busyw[i] == 1'b0 && lvlw[i] == 3'd0) && w < 6 * FLEN) begin
            tick();
            w++;
        end
        chk(nm, 32'(w < 6 * FLEN), 32'd1);
    endtask

    // decode UART frames from the recorded pin trace, sampling each bit
    // in its second cycle
    function automatic int decode(input int i, input int from, input int to);
        int n, s;
        logic [7:0] by[5];
        n = 0;
        s = from;
        while (s <= to) begin
            if (trace[i][s] == 1'b0 && trace[i][s-1] == 1'b1) begin
                for (int b = 0; b < 5; b++) begin
                    for (int k = 0; k < 10; k++) begin
                        logic v;
                        v = trace[i][s + (b * 10 + k) * CD + 1];
                        if (k == 0 && v != 1'b0) dbad++;
                        else if (k == 9 && v != 1'b1) dbad++;
                        else if (k > 0 && k < 9) by[b][k-1] = v;
                    end
                end
                if (by[0] != 8'hA5) dbad++;
                if (n < 8) dw[n] = {by[1], by[2], by[3], by[4]};
                n++;
                s += FLEN;
            end else begin
                s++;
            end
        end
        return n;
    endfunction

    initial begin
        int t0, t1, bc, lowc, nf;
        for (int i = 0; i < 2; i++) begin
            samp[i] = 1'b0; vint[i] = '0; vfrac[i] = '0; en[i] = 1'b1; clr[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", 32'(txw[i]), 32'd1);
            chk("rst_busy", 32'(busyw[i]), 32'd0);
            chk("rst_ovf", 32'(ovfw[i]), 32'd0);
            chk("rst_lvl", 32'(lvlw[i]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // single sample: A5 00 0A 80 00, tx falls one cycle after the push
        t0 = cyc;
        strobe(0, 16'h000A, 16'h8000);
        chk("t1_lvl_push", 32'(lvlw[0]), 32'd1);
        chk("t1_tx_push", 32'(txw[0]), 32'd1);
        tick();
        chk("t1_tx_start", 32'(txw[0]), 32'd0);
        chk("t1_busy_start", 32'(busyw[0]), 32'd1);
        bc = 1;
        repeat (FLEN) begin
            tick();
            if (busyw[0]) bc++;
        end
        chk("t1_busy_len", 32'(bc), 32'd200);
        dbad = 0;
        nf = decode(0, t0, cyc);
        chk("t1_nframes", 32'(nf), 32'd1);
        chk("t1_word", dw[0], 32'h000A_8000);
        chk("t1_framing", 32'(dbad), 32'd0);

        // decimation by 3: six strobes carry v_int 1 and 4 only
        t0 = cyc;
        for (int v = 1; v <= 6; v++) strobe(1, 16'(v), 16'h0000);
        repeat (2 * FLEN + 20) tick();
        dbad = 0;
        nf = decode(1, t0, cyc);
        chk("t2_nframes", 32'(nf), 32'd2);
        chk("t2_word0", dw[0], 32'h0001_0000);
        chk("t2_word1", dw[1], 32'h0004_0000);
        chk("t2_framing", 32'(dbad), 32'd0);

        // 8 strobes during a frame: 1 popped, 4 queued, 3 dropped
        t0 = cyc;
        for (int n = 0; n < 8; n++) strobe(0, 16'h0010 + 16'(n), 16'h00F0 + 16'(n));
        chk("t3_lvl_full", 32'(lvlw[0]), 32'd4);
        chk("t3_ovf_set", 32'(ovfw[0]), 32'd1);
        wait_drain(0, "t3_drain");
        dbad = 0;
        nf = decode(0, t0, cyc);
        chk("t3_nframes", 32'(nf), 32'd5);
        chk("t3_first", dw[0], 32'h0010_00F0);
        chk("t3_last", dw[4], 32'h0014_00F4);
        chk("t3_ovf_sticky", 32'(ovfw[0]), 32'd1);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("t3_ovf_clr", 32'(ovfw[0]), 32'd0);
        for (int n = 0; n < 5; n++) strobe(0, 16'h0020 + 16'(n), 16'h0000);
        samp[0] = 1'b1; tick();
        samp[0] = 1'b0; clr[0] = 1'b1; vint[0] = 16'h0099; tick();
        clr[0] = 1'b0;
        chk("t3_drop_beats_clr", 32'(ovfw[0]), 32'd1);
        chk("t3_lvl_still_full", 32'(lvlw[0]), 32'd4);

        // push on the same edge as the IDLE pop while full
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("t4_ovf_clr", 32'(ovfw[0]), 32'd0);
        samp[0] = 1'b1;
        bc = 0;
        while (busyw[0] == 1'b1 && bc < FLEN + 10) begin
            tick();
            bc++;
        end
        chk("t4_frame_end", 32'(bc < FLEN + 10), 32'd1);
        samp[0] = 1'b0; vint[0] = 16'hBEEF; vfrac[0] = 16'h0001;
        tick();
        chk("t4_lvl", 32'(lvlw[0]), 32'd4);
        chk("t4_ovf", 32'(ovfw[0]), 32'd0);
        chk("t4_busy", 32'(busyw[0]), 32'd1);

        // reset during a data bit of byte 2
        repeat (90) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx_rst", 32'(txw[0]), 32'd1);
        chk("t5_lvl_rst", 32'(lvlw[0]), 32'd0);
        chk("t5_busy_rst", 32'(busyw[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        lowc = 0;
        repeat (300) begin
            tick();
            if (txw[0] == 1'b0) lowc++;
        end
        chk("t5_no_resume", 32'(lowc), 32'd0);

        // enable low: queued words still go out, strobes ignored, dcnt held
        t0 = cyc;
        for (int n = 0; n < 4; n++) strobe(0, 16'h0060 + 16'(n), 16'h0000);
        en[0] = 1'b0;
        for (int n = 0; n < 5; n++) strobe(0, 16'h0070 + 16'(n), 16'h0000);
        chk("t6_lvl_held", 32'(lvlw[0]), 32'd3);
        en[0] = 1'b1;
        t1 = cyc;
        strobe(1, 16'h00A1, 16'h0000);
        en[1] = 1'b0;
        for (int n = 0; n < 5; n++) strobe(1, 16'h00B0 + 16'(n), 16'h0000);
        en[1] = 1'b1;
        strobe(1, 16'h00A2, 16'h0000);
        strobe(1, 16'h00A3, 16'h0000);
        strobe(1, 16'h00A4, 16'h0000);
        wait_drain(0, "t6_drain0");
        wait_drain(1, "t6_drain1");
        dbad = 0;
        nf = decode(0, t0, cyc);
        chk("t6_nframes0", 32'(nf), 32'd4);
        chk("t6_last0", dw[3], 32'h0063_0000);
        nf = decode(1, t1, cyc);
        chk("t6_nframes1", 32'(nf), 32'd2);
        chk("t6_dcnt_held0", dw[0], 32'h00A1_0000);
        chk("t6_dcnt_held1", dw[1], 32'h00A4_0000);
        chk("t6_framing", 32'(dbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
